led_chaser: RTL and testbench

- Parametrised successor to the fixed 16-LED holiday-light chaser.
- Drives an N-LED bar with a lit window of selectable length. Supported modes are rotate-with-wrap, bounce, and blink, in either direction.
- The start/pause button is synchronised and debounced inside clk. It is never used as a clock.
- Sits between the board switch/button inputs and the LED pins.

---
 rtl/led_pkg.sv | 17 +
 rtl/button_debounce.sv | 46 ++++
 rtl/led_chaser.sv | 173 +++++++++++++++++
 tb/tb_led_chaser.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the LED chaser: display modes and run-control FSM states.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability debounce, rising-edge pulse.
module button_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press_pulse
);

  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

  logic          sync_p0;
  logic          sync_p1;
  logic [DW-1:0] db_cnt;
  logic          level_d;

  // Synchroniser keeps sampling through reset so a held button is already settled at release
  always_ff @(posedge clk) begin
    sync_p0 <= btn_in;
    sync_p1 <= sync_p0;
  end

  // Debounce stage: during reset the accepted level follows the pin, so no edge is seen afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= sync_p1;
      level_d <= sync_p1;
      db_cnt  <= '0;
    end else begin
      level_d <= level;
      if (sync_p1 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DB_CYCLES - 1)) begin
        level  <= sync_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign press_pulse = level & ~level_d;

endmodule

// File: rtl/led_chaser.sv
// N-LED chaser: rotate/bounce/blink a window of selectable length, start/pause on a button.
module led_chaser
  import led_pkg::*;
#(
  parameter int N_LEDS    = 16,
  parameter int W_SEL     = 3,
  parameter int CNT_MAX   = 100_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic [W_SEL-1:0]  switch,
  output logic [N_LEDS-1:0] led,
  output logic              running
);

  localparam int PW = $clog2(N_LEDS);
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int AW = PW + 1;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     pos;
  logic [PW-1:0]     pos_nxt;
  logic              bdir;
  logic              bdir_cur;
  logic              bdir_nxt;
  logic              phase;
  logic              phase_nxt;
  mode_t             mode_eff;
  mode_t             mode_q;
  logic              db_level;
  logic              db_press;
  logic              press;
  logic              tick;
  logic [AW-1:0]     pos_w;
  logic [AW-1:0]     len_w;
  logic [AW-1:0]     lim_w;
  logic [AW-1:0]     up_sum;
  logic [AW-1:0]     dn_sum;
  logic [AW-1:0]     rot_up;
  logic [AW-1:0]     rot_dn;
  logic [N_LEDS-1:0] pat_p0;

  button_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (button),
    .level      (db_level),
    .press_pulse(db_press)
  );

  assign press = db_press & db_level;

  always_comb begin
    case (mode)
      MODE_BOUNCE: mode_eff = MODE_BOUNCE;
      MODE_BLINK:  mode_eff = MODE_BLINK;
      default:     mode_eff = MODE_ROTATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (press) state_nxt = RUN;
      RUN:     if (press) state_nxt = PAUSE;
      PAUSE:   if (press) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign running = (state == RUN);
  assign tick    = (state == RUN) && (cnt == CW'(CNT_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) cnt <= '0;
    else if (state == RUN)    cnt <= tick ? '0 : cnt + CW'(1);
  end

  // Modulo arithmetic is carried one bit wider so non-power-of-two bar lengths wrap correctly
  assign pos_w  = AW'(pos);
  assign len_w  = AW'(switch) + AW'(1);
  assign lim_w  = AW'(N_LEDS) - len_w;
  assign up_sum = pos_w + AW'(1);
  assign dn_sum = pos_w + AW'(N_LEDS - 1);
  assign rot_up = (up_sum >= AW'(N_LEDS)) ? up_sum - AW'(N_LEDS) : up_sum;
  assign rot_dn = (dn_sum >= AW'(N_LEDS)) ? dn_sum - AW'(N_LEDS) : dn_sum;

  // Bounce direction is reloaded from dir on the first cycle bounce is selected
  assign bdir_cur = (mode_q != MODE_BOUNCE) ? dir : bdir;

  always_comb begin
    pos_nxt   = pos;
    bdir_nxt  = bdir_cur;
    phase_nxt = (mode_eff == MODE_BLINK) ? phase : 1'b1;
    if (tick) begin
      case (mode_eff)
        MODE_BOUNCE: begin
          if (pos_w > lim_w) begin
            pos_nxt  = PW'(lim_w);
            bdir_nxt = 1'b1;
          end else if (!bdir_cur) begin
            if (pos_w == lim_w) begin
              bdir_nxt = 1'b1;
              pos_nxt  = (pos_w == '0) ? pos : pos - PW'(1);
            end else begin
              pos_nxt = pos + PW'(1);
            end
          end else begin
            if (pos_w == '0) begin
              bdir_nxt = 1'b0;
              pos_nxt  = (lim_w == '0) ? pos : pos + PW'(1);
            end else begin
              pos_nxt = pos - PW'(1);
            end
          end
        end
        MODE_BLINK: phase_nxt = ~phase;
        default:    pos_nxt = dir ? PW'(rot_dn) : PW'(rot_up);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos    <= '0;
      bdir   <= dir;
      phase  <= 1'b1;
      mode_q <= MODE_ROTATE;
    end else begin
      pos    <= pos_nxt;
      bdir   <= bdir_nxt;
      phase  <= phase_nxt;
      mode_q <= mode_eff;
    end
  end

  // Pattern stage: window decode from pos/len/mode/phase, registered onto the pins
  always_comb begin
    pat_p0 = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      case (mode_eff)
        MODE_BOUNCE:
          pat_p0[i] = (AW'(i) >= pos_w) && (AW'(i) < pos_w + len_w);
        MODE_BLINK:
          pat_p0[i] = phase && (((AW'(i) >= pos_w) ? AW'(i) - pos_w
                                                   : AW'(i) + AW'(N_LEDS) - pos_w) < len_w);
        default:
          pat_p0[i] = ((AW'(i) >= pos_w) ? AW'(i) - pos_w
                                         : AW'(i) + AW'(N_LEDS) - pos_w) < len_w;
      endcase
    end
    if (state == IDLE) pat_p0 = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) led <= '0;
    else     led <= pat_p0;
  end

endmodule

// File: tb/tb_led_chaser.sv
// Scoreboard bench for led_chaser (16 LEDs, 4-cycle tick, 2-cycle debounce).
module tb_led_chaser;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        button;
  logic        dir;
  logic [1:0]  mode;
  logic [2:0]  switch;
  logic [15:0] led;
  logic        running;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  led_chaser #(
    .N_LEDS   (16),
    .W_SEL    (3),
    .CNT_MAX  (4),
    .DB_CYCLES(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .dir    (dir),
    .mode   (mode),
    .switch (switch),
    .led    (led),
    .running(running)
  );

  function automatic logic [15:0] rot_pat(int p, int len);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < len; k++) v[(p + k) % N] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] bounce_pat(int p, int len);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < len; k++) if (p + k < N) v[p + k] = 1'b1;
    return v;
  endfunction

  // Pops one expected value per observed LED change
  task automatic drain();
    logic [15:0] prev;
    logic [15:0] expv;
    int          n;
    prev = led;
    while (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (led === prev && n < 40);
      total++;
      if (led === prev) begin
        bad++;
        $display("FAIL led_step: no change in 40 cycles, led=%h required %h", led, expv);
        exp_q.delete();
        return;
      end
      if (led !== expv) begin
        bad++;
        $display("FAIL led_step: led=%h required %h", led, expv);
      end
      prev = led;
    end
  endtask

  task automatic press(output int lat);
    logic r0;
    r0  = running;
    lat = -1;
    button = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (running !== r0) begin
        lat = i;
        break;
      end
    end
    button = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; button = 1'b0; dir = 1'b0; mode = 2'b00; switch = 3'd0;
    repeat (3) @(negedge clk);
    total++;
    if (led !== 16'h0000) begin bad++; $display("FAIL reset_led: led=%h required 0000", led); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (running !== 1'b0) begin bad++; $display("FAIL reset_running: running=%b required 0", running); end
    total++;
    if (led !== 16'h0000) begin bad++; $display("FAIL idle_led: led=%h required 0000", led); end
  endtask

  task automatic test_rotate_start();
    int lat;
    press(lat);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL start_latency: cycles=%0d required 5", lat); end
    for (int p = 0; p < 16; p++) exp_q.push_back(rot_pat(p, 1));
    exp_q.push_back(rot_pat(0, 1));
    drain();
  endtask

  task automatic test_rotate_wrap();
    switch = 3'd2;
    for (int p = 0; p < 16; p++) exp_q.push_back(rot_pat(p, 3));
    drain();
    dir = 1'b1;
    for (int p = 14; p >= 0; p--) exp_q.push_back(rot_pat(p, 3));
    exp_q.push_back(rot_pat(15, 3));
    drain();
  endtask

  task automatic test_bounce();
    int lat;
    mode = 2'b01; switch = 3'd3; dir = 1'b0;
    do_reset();
    press(lat);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL bounce_latency: cycles=%0d required 5", lat); end
    for (int p = 0; p <= 12; p++) exp_q.push_back(bounce_pat(p, 4));
    for (int p = 11; p >= 0; p--) exp_q.push_back(bounce_pat(p, 4));
    for (int p = 1; p <= 12; p++) exp_q.push_back(bounce_pat(p, 4));
    drain();
    switch = 3'd7;
    @(negedge clk);
    total++;
    if (led !== 16'hF000) begin bad++; $display("FAIL bounce_clip: led=%h required f000", led); end
    exp_q.push_back(16'hFF00);
    exp_q.push_back(16'h7F80);
    drain();
  endtask

  task automatic test_blink_pause();
    int          lat;
    int          n;
    logic        changed;
    logic [15:0] held;
    switch = 3'd1;
    exp_q.push_back(bounce_pat(7, 2));
    exp_q.push_back(bounce_pat(6, 2));
    exp_q.push_back(bounce_pat(5, 2));
    drain();
    mode = 2'b10;
    for (int j = 0; j < 2; j++) begin
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0060);
    end
    drain();
    press(lat);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL pause_latency: cycles=%0d required 5", lat); end
    held = led;
    changed = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (led !== held) changed = 1'b1;
    end
    total++;
    if (changed || led !== 16'h0000) begin
      bad++; $display("FAIL pause_freeze: led=%h changed=%b required 0000 unchanged", led, changed);
    end
    press(lat);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL resume_latency: cycles=%0d required 5", lat); end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (led === 16'h0000 && n < 20);
    total++;
    if (n !== 3) begin bad++; $display("FAIL resume_remaining: cycles=%0d required 3", n); end
    total++;
    if (led !== 16'h0060) begin bad++; $display("FAIL resume_led: led=%h required 0060", led); end
    exp_q.push_back(16'h0000);
    drain();
    mode = 2'b00;
    @(negedge clk);
    total++;
    if (led !== rot_pat(5, 2)) begin bad++; $display("FAIL leave_blink: led=%h required 0060", led); end
    mode = 2'b10;
    @(negedge clk);
    total++;
    if (led !== 16'h0060) begin bad++; $display("FAIL blink_phase_reset: led=%h required 0060", led); end
  endtask

  task automatic test_glitch_reset();
    int lat;
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (running !== 1'b1) begin bad++; $display("FAIL glitch_ignored: running=%b required 1", running); end
    rst = 1'b1;
    button = 1'b1;
    @(negedge clk);
    total++;
    if (led !== 16'h0000 || running !== 1'b0) begin
      bad++; $display("FAIL reset_midrun: led=%h running=%b required 0000/0", led, running);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (running !== 1'b0 || led !== 16'h0000) begin
      bad++; $display("FAIL held_after_reset: led=%h running=%b required 0000/0", led, running);
    end
    button = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (running !== 1'b0) begin bad++; $display("FAIL release_after_reset: running=%b required 0", running); end
    press(lat);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL fresh_press: cycles=%0d required 5", lat); end
  endtask

  initial begin
    test_reset();
    test_rotate_start();
    test_rotate_wrap();
    test_bounce();
    test_blink_pause();
    test_glitch_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
